vdma_burst_scheduler: RTL and testbench
=======================================

Name: vdma_burst_scheduler

Overview:
- Sequences one VDMA channel's per-frame burst traffic and drives the frame address generator's `new_base`, `burst_done` and `tail_done` inputs.
- Rotates across FRAME_BUFS frame buffers and issues one req/ack burst request per burst, gated on line-FIFO readiness.
- Sits between the video line FIFO, the AXI burst master and the address generator.

Parameters:
- ASIZE, 29, address width.
- FRAME_BUFS, 3, number of frame buffers in rotation (1..4).
- LSIZE, 12, width of the line-count config and counter.
- BSIZE, 8, width of the bursts-per-line config and counter.

Ports:
- clock  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allows new frames to start.
- cfg_base0  in  ASIZE  base address of buffer 0.
- cfg_frame_stride  in  ASIZE  address distance between buffers.
- cfg_lines  in  LSIZE  lines per frame.
- cfg_bursts_per_line  in  BSIZE  full bursts per line.
- cfg_tail_en  in  1  one extra tail burst per line.
- frame_start  in  1  one-cycle frame sync pulse.
- fifo_ready  in  1  line FIFO holds data for one burst.
- req  out  1  burst request to AXI master.
- ack  in  1  burst accepted (valid only while req=1).
- xfer_done  in  1  one-cycle pulse: accepted burst finished.
- new_base  out  1  one-cycle load strobe to the address generator.
- baseaddr  out  ASIZE  selected buffer base.
- burst_done  out  1  one-cycle pulse after a full burst.
- tail_done  out  1  one-cycle pulse after a tail burst.
- buf_index  out  2  buffer currently or last written.
- frame_busy  out  1  high from LOAD until FRAME_END inclusive.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_skip  out  1  one-cycle pulse when `frame_start` is ignored.

Behaviour:
- Reset: every output is 0; `buf_index` is 0; all counters are 0; state is IDLE. Reset mid-frame aborts immediately, with no done pulses.
- All outputs are registered.
- State IDLE: `frame_start` && `enable` -> LOAD. `frame_start` with `enable`=0 is ignored silently.
- State LOAD: single cycle.
  - Latches `cfg_lines`, `cfg_bursts_per_line` and `cfg_tail_en`; config changes mid-frame have no effect.
  - `baseaddr` = `cfg_base0` + `buf_index` * `cfg_frame_stride`, truncated to ASIZE bits (wraps modulo 2^ASIZE).
  - `new_base` = 1 for this cycle only.
  - Clears the line and burst counters.
  - Bursts per line = `cfg_bursts_per_line` + `cfg_tail_en`. If latched lines = 0 or bursts per line = 0 -> FRAME_END; otherwise -> WAIT_DATA.
- State WAIT_DATA: stays while `fifo_ready`=0. `fifo_ready`=1 -> REQ.
- State REQ: `req`=1 and held until a cycle with `ack`=1. `req` falls in the cycle after the ack, then -> WAIT_DONE.
- State WAIT_DONE: waits for `xfer_done` -> NEXT. An `xfer_done` seen in any other state is ignored.
- State NEXT: single cycle.
  - Tail burst = `cfg_tail_en`=1 and the burst counter equals `cfg_bursts_per_line`. It pulses `tail_done`; any other burst pulses `burst_done`. Never both.
  - Increments the burst counter. At end of line, clears the burst counter and increments the line counter.
  - After the last burst of the last line -> FRAME_END; otherwise -> WAIT_DATA.
  - Because of this structure, `burst_done`/`tail_done` pulses are always separated by at least 3 low cycles, so the address generator's edge detectors see every pulse.
- State FRAME_END: single cycle.
  - `frame_done` = 1.
  - `buf_index` <= (`buf_index` + 1) mod FRAME_BUFS.
  - -> IDLE.
  - `frame_start` in this cycle is skipped.
- `frame_busy` = 1 in every state except IDLE.
- `frame_start` while `frame_busy`=1 produces `frame_skip`=1 on the next cycle. The frame is not queued.
- Deasserting `enable` mid-frame lets the frame complete normally, then the block stays in IDLE.
- Minimum latency:
  - `frame_start` -> `new_base`: 1 cycle.
  - `frame_start` -> `req`: 3 cycles (with `fifo_ready` held).

Test Plan:
- Reset with lines=2, bpl=3, tail_en=0, base0=0x1000, stride=0x100000, `fifo_ready`/`ack`/`xfer_done` always ready, then one `frame_start` -> 6 reqs, 6 `burst_done` pulses, 0 `tail_done`, `baseaddr`=0x1000, single `frame_done`, then `buf_index`=1.
- Same config with tail_en=1 -> 8 bursts; the pulse pattern per line is burst_done ×3 then tail_done ×1; `frame_done` after the 8th.
- Three consecutive frames, then a fourth (FRAME_BUFS=3) -> `baseaddr` sequence 0x1000, 0x101000, 0x201000, 0x1000.
- Hold `ack` low for 10 cycles in REQ -> `req` stays high for exactly those 10 cycles plus the ack cycle. Drop `fifo_ready` mid-line -> no `req` until it returns.
- `frame_start` pulse during WAIT_DONE -> `frame_skip` pulse 1 cycle later, frame continues unaffected, and no extra `new_base`.
- Assert `rst` during WAIT_DONE of line 1 -> all outputs 0 immediately with no done pulses. After release, a new frame starts from `buf_index`=0. Also lines=0 -> `new_base` then `frame_done` with no `req`.

Source files
------------

// File: rtl/vdma_burst_scheduler.sv
// Per-frame burst sequencer for one VDMA channel: rotates frame buffers, issues
// req/ack bursts gated on line-FIFO readiness and strobes the address generator.
module vdma_burst_scheduler #(
   parameter int ASIZE      = 29,
   parameter int FRAME_BUFS = 3,
   parameter int LSIZE      = 12,
   parameter int BSIZE      = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             enable,
   input  logic [ASIZE-1:0] cfg_base0,
   input  logic [ASIZE-1:0] cfg_frame_stride,
   input  logic [LSIZE-1:0] cfg_lines,
   input  logic [BSIZE-1:0] cfg_bursts_per_line,
   input  logic             cfg_tail_en,
   input  logic             frame_start,
   input  logic             fifo_ready,
   output logic             req,
   input  logic             ack,
   input  logic             xfer_done,
   output logic             new_base,
   output logic [ASIZE-1:0] baseaddr,
   output logic             burst_done,
   output logic             tail_done,
   output logic [1:0]       buf_index,
   output logic             frame_busy,
   output logic             frame_done,
   output logic             frame_skip
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_DATA,
      S_REQ,
      S_WAIT_DONE,
      S_NEXT,
      S_FRAME_END
   } state_t;

   localparam logic [LSIZE-1:0] L_ONE = LSIZE'(1);
   localparam logic [BSIZE:0]   B_ONE = (BSIZE + 1)'(1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [LSIZE-1:0] r_lines;
   logic [LSIZE-1:0] r_line_cnt;
   logic [BSIZE-1:0] r_bpl_full;
   logic             r_tail_en;
   logic [BSIZE:0]   r_bpl_total;
   logic [BSIZE:0]   r_burst_cnt;

   logic             r_req;
   logic             r_new_base;
   logic [ASIZE-1:0] r_baseaddr;
   logic             r_burst_done;
   logic             r_tail_done;
   logic [1:0]       r_buf_index;
   logic             r_frame_busy;
   logic             r_frame_done;
   logic             r_frame_skip;

   logic [BSIZE:0]   w_cfg_total;
   logic             w_line_end;
   logic             w_last_line;
   logic             w_is_tail;
   logic [ASIZE-1:0] w_load_base;

   assign w_cfg_total = {1'b0, cfg_bursts_per_line} + {{BSIZE{1'b0}}, cfg_tail_en};
   assign w_line_end  = (r_burst_cnt == r_bpl_total - B_ONE);
   assign w_last_line = (r_line_cnt == r_lines - L_ONE);
   assign w_is_tail   = r_tail_en && (r_burst_cnt == {1'b0, r_bpl_full});
   assign w_load_base = cfg_base0 + ASIZE'(r_buf_index) * cfg_frame_stride;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:      if (frame_start && enable) w_state_nxt = S_LOAD;
         S_LOAD:      w_state_nxt = (cfg_lines == '0 || w_cfg_total == '0) ? S_FRAME_END
                                                                           : S_WAIT_DATA;
         S_WAIT_DATA: if (fifo_ready) w_state_nxt = S_REQ;
         S_REQ:       if (ack) w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (xfer_done) w_state_nxt = S_NEXT;
         S_NEXT:      w_state_nxt = (w_line_end && w_last_line) ? S_FRAME_END : S_WAIT_DATA;
         S_FRAME_END: w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: outputs are decoded from the next state and registered, so each one
   // is glitch-free yet lines up with the state it belongs to, with no extra cycle.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_lines      <= '0;
         r_line_cnt   <= '0;
         r_bpl_full   <= '0;
         r_tail_en    <= 1'b0;
         r_bpl_total  <= '0;
         r_burst_cnt  <= '0;
         r_req        <= 1'b0;
         r_new_base   <= 1'b0;
         r_baseaddr   <= '0;
         r_burst_done <= 1'b0;
         r_tail_done  <= 1'b0;
         r_buf_index  <= 2'd0;
         r_frame_busy <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_skip <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_req        <= (w_state_nxt == S_REQ);
         r_new_base   <= (w_state_nxt == S_LOAD);
         r_burst_done <= (w_state_nxt == S_NEXT) && !w_is_tail;
         r_tail_done  <= (w_state_nxt == S_NEXT) && w_is_tail;
         r_frame_busy <= (w_state_nxt != S_IDLE);
         r_frame_done <= (w_state_nxt == S_FRAME_END);
         r_frame_skip <= frame_start && r_frame_busy;

         if (w_state_nxt == S_LOAD) r_baseaddr <= w_load_base;

         unique case (r_state)
            S_LOAD: begin
               // Frame geometry is frozen here; later cfg changes wait for the next frame.
               r_lines     <= cfg_lines;
               r_bpl_full  <= cfg_bursts_per_line;
               r_tail_en   <= cfg_tail_en;
               r_bpl_total <= w_cfg_total;
               r_line_cnt  <= '0;
               r_burst_cnt <= '0;
            end
            S_NEXT: begin
               if (w_line_end) begin
                  r_burst_cnt <= '0;
                  r_line_cnt  <= r_line_cnt + L_ONE;
               end else begin
                  r_burst_cnt <= r_burst_cnt + B_ONE;
               end
            end
            S_FRAME_END: begin
               r_buf_index <= (r_buf_index == 2'(FRAME_BUFS - 1)) ? 2'd0 : r_buf_index + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign req        = r_req;
   assign new_base   = r_new_base;
   assign baseaddr   = r_baseaddr;
   assign burst_done = r_burst_done;
   assign tail_done  = r_tail_done;
   assign buf_index  = r_buf_index;
   assign frame_busy = r_frame_busy;
   assign frame_done = r_frame_done;
   assign frame_skip = r_frame_skip;

endmodule

// File: tb/tb_vdma_burst_scheduler.sv
// Directed self-checking bench for vdma_burst_scheduler: frame rotation, tail
// bursts, req/ack hold, FIFO stall, frame skip, mid-frame reset and empty frames.
module tb_vdma_burst_scheduler;

   localparam int ASIZE      = 29;
   localparam int FRAME_BUFS = 3;
   localparam int LSIZE      = 12;
   localparam int BSIZE      = 8;

   logic             clock = 1'b0;
   logic             rst;
   logic             enable;
   logic [ASIZE-1:0] cfg_base0;
   logic [ASIZE-1:0] cfg_frame_stride;
   logic [LSIZE-1:0] cfg_lines;
   logic [BSIZE-1:0] cfg_bursts_per_line;
   logic             cfg_tail_en;
   logic             frame_start;
   logic             fifo_ready;
   logic             req;
   logic             ack;
   logic             xfer_done;
   logic             new_base;
   logic [ASIZE-1:0] baseaddr;
   logic             burst_done;
   logic             tail_done;
   logic [1:0]       buf_index;
   logic             frame_busy;
   logic             frame_done;
   logic             frame_skip;

   int n_checks = 0;
   int n_errors = 0;

   int               m_reqs, m_bursts, m_tails, m_dones, m_loads, m_nb_idx, m_req_idx;
   logic [31:0]      m_tmask;
   logic [ASIZE-1:0] m_base;

   always #5 clock = ~clock;

   vdma_burst_scheduler #(
      .ASIZE(ASIZE), .FRAME_BUFS(FRAME_BUFS), .LSIZE(LSIZE), .BSIZE(BSIZE)
   ) dut (
      .clock(clock), .rst(rst), .enable(enable),
      .cfg_base0(cfg_base0), .cfg_frame_stride(cfg_frame_stride),
      .cfg_lines(cfg_lines), .cfg_bursts_per_line(cfg_bursts_per_line),
      .cfg_tail_en(cfg_tail_en), .frame_start(frame_start), .fifo_ready(fifo_ready),
      .req(req), .ack(ack), .xfer_done(xfer_done), .new_base(new_base),
      .baseaddr(baseaddr), .burst_done(burst_done), .tail_done(tail_done),
      .buf_index(buf_index), .frame_busy(frame_busy), .frame_done(frame_done),
      .frame_skip(frame_skip)
   );

   function automatic logic [63:0] all_outputs();
      return {26'd0, req, new_base, baseaddr, burst_done, tail_done, buf_index,
              frame_busy, frame_done, frame_skip};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sample_cycle(input int idx, inout logic prev_req, inout int pulse);
      if (req && !prev_req) begin
         m_reqs++;
         if (m_req_idx < 0) m_req_idx = idx;
      end
      prev_req = req;
      if (burst_done) begin
         m_bursts++;
         pulse++;
      end
      if (tail_done) begin
         m_tails++;
         if (pulse < 32) m_tmask[pulse] = 1'b1;
         pulse++;
      end
      if (new_base) begin
         m_loads++;
         m_base = baseaddr;
         if (m_nb_idx < 0) m_nb_idx = idx;
      end
      if (frame_done) m_dones++;
   endtask

   // Called just after a falling edge; pulses frame_start and watches the whole frame.
   task automatic run_frame(input logic drop_enable);
      int   pulse;
      logic prev_req;
      m_reqs = 0; m_bursts = 0; m_tails = 0; m_dones = 0; m_loads = 0;
      m_nb_idx = -1; m_req_idx = -1; m_tmask = '0; m_base = '0;
      pulse = 0; prev_req = 1'b0;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      if (drop_enable) enable = 1'b0;
      for (int idx = 0; idx < 400; idx++) begin
         sample_cycle(idx, prev_req, pulse);
         if (frame_done) break;
         @(negedge clock);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         sample_cycle(1000 + k, prev_req, pulse);
      end
   endtask

   initial begin
      int hi;
      int bcount;
      int cnt;
      logic got_done;

      rst = 1'b1; enable = 1'b1; frame_start = 1'b0;
      fifo_ready = 1'b1; ack = 1'b1; xfer_done = 1'b1;
      cfg_base0 = 29'h1000; cfg_frame_stride = 29'h100000;
      cfg_lines = 12'd2; cfg_bursts_per_line = 8'd3; cfg_tail_en = 1'b0;

      repeat (2) @(negedge clock);
      check("reset_outputs", all_outputs(), 64'd0);
      rst = 1'b0;
      @(negedge clock);
      check("idle_after_reset", all_outputs(), 64'd0);

      // Frame 1: 2 lines x 3 full bursts, buffer 0
      run_frame(1'b0);
      check("f1_new_base_latency", 64'(m_nb_idx), 64'd0);
      check("f1_req_latency", 64'(m_req_idx), 64'd2);
      check("f1_reqs", 64'(m_reqs), 64'd6);
      check("f1_burst_done", 64'(m_bursts), 64'd6);
      check("f1_tail_done", 64'(m_tails), 64'd0);
      check("f1_new_base_count", 64'(m_loads), 64'd1);
      check("f1_baseaddr", 64'(m_base), 64'h1000);
      check("f1_frame_done", 64'(m_dones), 64'd1);
      check("f1_buf_index", 64'(buf_index), 64'd1);
      check("f1_idle", 64'(frame_busy), 64'd0);

      // Frame 2: tail burst enabled, buffer 1
      cfg_tail_en = 1'b1;
      run_frame(1'b0);
      check("f2_reqs", 64'(m_reqs), 64'd8);
      check("f2_burst_done", 64'(m_bursts), 64'd6);
      check("f2_tail_done", 64'(m_tails), 64'd2);
      check("f2_pulse_pattern", 64'(m_tmask), 64'h88);
      check("f2_baseaddr", 64'(m_base), 64'h101000);
      check("f2_frame_done", 64'(m_dones), 64'd1);
      check("f2_buf_index", 64'(buf_index), 64'd2);

      // Frames 3 and 4: rotation wraps after the third buffer
      cfg_tail_en = 1'b0;
      run_frame(1'b0);
      check("f3_baseaddr", 64'(m_base), 64'h201000);
      check("f3_buf_index", 64'(buf_index), 64'd0);
      run_frame(1'b1);
      check("f4_baseaddr", 64'(m_base), 64'h1000);
      check("f4_reqs_enable_dropped", 64'(m_reqs), 64'd6);
      check("f4_frame_done", 64'(m_dones), 64'd1);
      check("f4_buf_index", 64'(buf_index), 64'd1);

      // enable is low now: frame_start must be ignored silently
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      check("disabled_no_load", 64'({new_base, frame_skip, frame_busy}), 64'd0);
      @(negedge clock);
      check("disabled_stays_idle", 64'({new_base, frame_busy}), 64'd0);
      enable = 1'b1;

      // Frame 5: ack held off, skip during WAIT_DONE, fifo stall mid-line
      cfg_lines = 12'd1; cfg_bursts_per_line = 8'd2;
      ack = 1'b0; xfer_done = 1'b0;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      cnt = 0;
      while (!req && cnt < 20) begin
         @(negedge clock);
         cnt++;
      end
      check("f5_req_seen", 64'(req), 64'd1);
      hi = 0;
      for (int i = 0; i < 11; i++) begin
         if (req) hi++;
         if (i == 10) ack = 1'b1;
         @(negedge clock);
      end
      ack = 1'b0;
      check("f5_req_hold_cycles", 64'(hi), 64'd11);
      check("f5_req_falls_after_ack", 64'(req), 64'd0);

      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      check("f5_skip_pulse", 64'({frame_skip, new_base}), 64'b10);
      @(negedge clock);
      check("f5_skip_single", 64'({frame_skip, new_base, frame_busy}), 64'b001);

      xfer_done = 1'b1;
      @(negedge clock);
      xfer_done = 1'b0;
      check("f5_first_burst_done", 64'(burst_done), 64'd1);
      fifo_ready = 1'b0;
      hi = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (req) hi++;
      end
      check("f5_no_req_while_fifo_empty", 64'(hi), 64'd0);
      fifo_ready = 1'b1; ack = 1'b1; xfer_done = 1'b1;
      hi = 0; bcount = 0; got_done = 1'b0;
      for (int i = 0; i < 30 && !got_done; i++) begin
         @(negedge clock);
         if (req) hi++;
         if (burst_done) bcount++;
         if (frame_done) got_done = 1'b1;
      end
      check("f5_frame_done", 64'(got_done), 64'd1);
      check("f5_second_req", 64'(hi), 64'd1);
      check("f5_second_burst", 64'(bcount), 64'd1);
      @(negedge clock);
      check("f5_buf_index", 64'(buf_index), 64'd2);

      // Frame 6: reset while waiting on the first burst of line 1
      cfg_lines = 12'd2; cfg_bursts_per_line = 8'd3;
      xfer_done = 1'b0;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      for (int b = 0; b < 4; b++) begin
         cnt = 0;
         while (!req && cnt < 20) begin
            @(negedge clock);
            cnt++;
         end
         @(negedge clock);
         if (b < 3) begin
            xfer_done = 1'b1;
            @(negedge clock);
            xfer_done = 1'b0;
         end
      end
      check("f6_mid_frame_busy", 64'({frame_busy, req, buf_index}), 64'b1010);
      #2;
      rst = 1'b1;
      xfer_done = 1'b1;
      #1;
      check("f6_async_reset_clears", all_outputs(), 64'd0);
      hi = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (i == 1) rst = 1'b0;
         if (burst_done || tail_done || frame_done || new_base || frame_busy) hi++;
      end
      check("f6_no_pulses_after_reset", 64'(hi), 64'd0);

      run_frame(1'b0);
      check("f7_baseaddr_from_buf0", 64'(m_base), 64'h1000);
      check("f7_reqs", 64'(m_reqs), 64'd6);
      check("f7_buf_index", 64'(buf_index), 64'd1);

      // Frame 8: zero lines -> load then frame end, no bursts
      cfg_lines = 12'd0;
      run_frame(1'b0);
      check("f8_new_base", 64'(m_loads), 64'd1);
      check("f8_baseaddr", 64'(m_base), 64'h101000);
      check("f8_no_req", 64'(m_reqs), 64'd0);
      check("f8_no_bursts", 64'(m_bursts + m_tails), 64'd0);
      check("f8_frame_done", 64'(m_dones), 64'd1);
      check("f8_buf_index", 64'(buf_index), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
